// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the hardwired control sequencer:
// opcodes, ALU codes, state/class encodings, strobe bundle.
package cpu_ctrl_pkg;

  localparam int OPC_W = 5;
  localparam int ALU_W = 5;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_NONE = 5'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'd2;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'd3;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'd4;
  localparam logic [ALU_W-1:0] ALU_MUL  = 5'd5;
  localparam logic [ALU_W-1:0] ALU_DIV  = 5'd6;

  localparam logic [1:0] FLT_NONE    = 2'd0;
  localparam logic [1:0] FLT_ILLEGAL = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    C_RALU, C_IALU, C_MULDIV, C_LD, C_ST,
    C_BR, C_NOP, C_HALT, C_ILL
  } class_e;

  typedef struct packed {
    logic pc_out;
    logic zlo_out;
    logic zhi_out;
    logic mdr_out;
    logic c_out;
    logic ba_out;
    logic r_out;
    logic pc_in;
    logic mar_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic r_in;
    logic hi_in;
    logic lo_in;
    logic con_in;
    logic inc_pc;
    logic read;
    logic write;
    logic zlo_in;
    logic zhi_in;
    logic gra;
    logic grb;
    logic grc;
    logic [ALU_W-1:0] alu;
  } ctrl_t;

  function automatic class_e op_class(
    input logic [OPC_W-1:0] op
  );
    class_e c;
    c = C_ILL;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: c = C_RALU;
      OP_ADDI, OP_ANDI, OP_ORI:      c = C_IALU;
      OP_MUL, OP_DIV:                c = C_MULDIV;
      OP_LD:                         c = C_LD;
      OP_ST:                         c = C_ST;
      OP_BR:                         c = C_BR;
      OP_NOP:                        c = C_NOP;
      OP_HALT:                       c = C_HALT;
      default:                       c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [ALU_W-1:0] op_alu(
    input logic [OPC_W-1:0] op
  );
    logic [ALU_W-1:0] a;
    a = ALU_NONE;
    case (op)
      OP_ADD, OP_ADDI: a = ALU_ADD;
      OP_SUB:          a = ALU_SUB;
      OP_AND, OP_ANDI: a = ALU_AND;
      OP_OR, OP_ORI:   a = ALU_OR;
      OP_MUL:          a = ALU_MUL;
      OP_DIV:          a = ALU_DIV;
      default:         a = ALU_NONE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Moore strobe decoder: (state, instruction class,
// condition flag) -> datapath control bundle.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e           i_state,
  input  class_e           i_cls,
  input  logic [ALU_W-1:0] i_alu,
  input  logic             i_con,
  output ctrl_t            o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      S_T0: begin
        o_ctrl.pc_out = 1'b1;
        o_ctrl.mar_in = 1'b1;
        o_ctrl.inc_pc = 1'b1;
        o_ctrl.zlo_in = 1'b1;
      end
      S_T1: begin
        o_ctrl.zlo_out = 1'b1;
        o_ctrl.pc_in   = 1'b1;
        o_ctrl.read    = 1'b1;
        o_ctrl.mdr_in  = 1'b1;
      end
      S_T2: begin
        o_ctrl.mdr_out = 1'b1;
        o_ctrl.ir_in   = 1'b1;
      end
      S_T3: begin
        unique case (i_cls)
          C_RALU, C_IALU: begin
            o_ctrl.grb   = 1'b1;
            o_ctrl.r_out = 1'b1;
            o_ctrl.y_in  = 1'b1;
          end
          C_MULDIV: begin
            o_ctrl.gra   = 1'b1;
            o_ctrl.r_out = 1'b1;
            o_ctrl.y_in  = 1'b1;
          end
          C_LD, C_ST: begin
            o_ctrl.grb    = 1'b1;
            o_ctrl.ba_out = 1'b1;
            o_ctrl.y_in   = 1'b1;
          end
          C_BR: begin
            o_ctrl.gra    = 1'b1;
            o_ctrl.r_out  = 1'b1;
            o_ctrl.con_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (i_cls)
          C_RALU: begin
            o_ctrl.grc    = 1'b1;
            o_ctrl.r_out  = 1'b1;
            o_ctrl.zlo_in = 1'b1;
            o_ctrl.alu    = i_alu;
          end
          C_IALU: begin
            o_ctrl.c_out  = 1'b1;
            o_ctrl.zlo_in = 1'b1;
            o_ctrl.alu    = i_alu;
          end
          C_MULDIV: begin
            o_ctrl.grb    = 1'b1;
            o_ctrl.r_out  = 1'b1;
            o_ctrl.zlo_in = 1'b1;
            o_ctrl.zhi_in = 1'b1;
            o_ctrl.alu    = i_alu;
          end
          C_LD, C_ST: begin
            o_ctrl.c_out  = 1'b1;
            o_ctrl.zlo_in = 1'b1;
            o_ctrl.alu    = ALU_ADD;
          end
          C_BR: begin
            o_ctrl.pc_out = 1'b1;
            o_ctrl.y_in   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (i_cls)
          C_RALU, C_IALU: begin
            o_ctrl.zlo_out = 1'b1;
            o_ctrl.gra     = 1'b1;
            o_ctrl.r_in    = 1'b1;
          end
          C_MULDIV: begin
            o_ctrl.zlo_out = 1'b1;
            o_ctrl.lo_in   = 1'b1;
          end
          C_LD, C_ST: begin
            o_ctrl.zlo_out = 1'b1;
            o_ctrl.mar_in  = 1'b1;
          end
          C_BR: begin
            o_ctrl.c_out  = 1'b1;
            o_ctrl.zlo_in = 1'b1;
            o_ctrl.alu    = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (i_cls)
          C_MULDIV: begin
            o_ctrl.zhi_out = 1'b1;
            o_ctrl.hi_in   = 1'b1;
          end
          C_LD: begin
            o_ctrl.read   = 1'b1;
            o_ctrl.mdr_in = 1'b1;
          end
          C_ST: begin
            o_ctrl.gra    = 1'b1;
            o_ctrl.r_out  = 1'b1;
            o_ctrl.mdr_in = 1'b1;
          end
          C_BR: begin
            o_ctrl.zlo_out = i_con;
            o_ctrl.pc_in   = i_con;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (i_cls)
          C_LD: begin
            o_ctrl.mdr_out = 1'b1;
            o_ctrl.gra     = 1'b1;
            o_ctrl.r_in    = 1'b1;
          end
          C_ST: o_ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_seq.sv
// Instruction-cycle sequencer with memory wait/timeout and halt.
// Build option CTRL_SINGLE_STEP_EN adds step_req single-stepping.
module cpu_control_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 5,
  parameter int ALU_OP_W    = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                run,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                step_req,
`endif
  input  logic [DATA_W-1:0]   IR,
  input  logic                mem_ready,
  input  logic                con_ff,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic                Cout,
  output logic                BAout,
  output logic                Rout,
  output logic                PCin,
  output logic                MARin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Rin,
  output logic                HIin,
  output logic                LOin,
  output logic                CONin,
  output logic                IncPC,
  output logic                Read,
  output logic                Write,
  output logic                Zin_low,
  output logic                Zin_high,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic [ALU_OP_W-1:0] operation,
  output logic [3:0]          step,
  output logic                halted,
  output logic [1:0]          fault
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e           r_state;
  state_e           w_next;
  state_e           w_done;
  logic [OPC_W-1:0] r_op;
  logic [OPC_W-1:0] w_ir_op;
  logic [OPC_W-1:0] w_op;
  class_e           w_cls;
  class_e           w_ir_cls;
  logic [CNT_W-1:0] r_wait;
  logic             w_wait_inc;
  logic             w_mem;
  logic             w_start;
  logic [1:0]       r_fault;
  logic [1:0]       w_fault_nxt;
  ctrl_t            w_ctrl;
  logic             w_unused_ir;

  assign w_ir_op  = OPC_W'(IR[DATA_W-1 -: OP_W]);
  assign w_unused_ir = ^IR[DATA_W-OP_W-1:0];
  // T3 decodes the live IR; later steps use the copy taken in T3
  assign w_op     = (r_state == S_T3) ? w_ir_op : r_op;
  assign w_cls    = op_class(w_op);
  assign w_ir_cls = op_class(w_ir_op);

  assign w_mem = (r_state == S_T1)
              || (r_state == S_T6 && w_cls == C_LD)
              || (r_state == S_T7 && w_cls == C_ST);

`ifdef CTRL_SINGLE_STEP_EN
  logic w_unused_run;
  assign w_unused_run = run;
  assign w_start = step_req;
  assign w_done  = S_IDLE;
`else
  assign w_start = run;
  assign w_done  = run ? S_T0 : S_IDLE;
`endif

  always_comb begin
    w_next      = r_state;
    w_fault_nxt = r_fault;
    w_wait_inc  = 1'b0;
    if (w_mem && !mem_ready) begin
      w_wait_inc = 1'b1;
      if (r_wait == CNT_W'(MEM_TIMEOUT - 1)) begin
        w_next      = S_HALT;
        w_fault_nxt = FLT_TIMEOUT;
      end
    end else begin
      unique case (r_state)
        S_IDLE: if (w_start) w_next = S_T0;
        S_T0:   w_next = S_T1;
        S_T1:   w_next = S_T2;
        S_T2:   w_next = (w_ir_cls == C_NOP) ? w_done : S_T3;
        S_T3: begin
          unique case (w_cls)
            C_HALT: w_next = S_HALT;
            C_ILL: begin
              w_next      = S_HALT;
              w_fault_nxt = FLT_ILLEGAL;
            end
            C_NOP:   w_next = w_done;
            default: w_next = S_T4;
          endcase
        end
        S_T4: w_next = S_T5;
        S_T5: w_next = (w_cls inside {C_RALU, C_IALU}) ? w_done : S_T6;
        S_T6: w_next = (w_cls inside {C_LD, C_ST}) ? S_T7 : w_done;
        S_T7: w_next = w_done;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_wait  <= '0;
      r_fault <= FLT_NONE;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault_nxt;
      if (r_state == S_T3) r_op <= w_ir_op;
      if (w_next != r_state) r_wait <= '0;
      else if (w_wait_inc) r_wait <= r_wait + 1'b1;
    end
  end

  cpu_ctrl_decode u_dec (
    .i_state (r_state),
    .i_cls   (w_cls),
    .i_alu   (op_alu(w_op)),
    .i_con   (con_ff),
    .o_ctrl  (w_ctrl)
  );

  assign PCout     = w_ctrl.pc_out;
  assign Zlowout   = w_ctrl.zlo_out;
  assign Zhighout  = w_ctrl.zhi_out;
  assign MDRout    = w_ctrl.mdr_out;
  assign Cout      = w_ctrl.c_out;
  assign BAout     = w_ctrl.ba_out;
  assign Rout      = w_ctrl.r_out;
  assign PCin      = w_ctrl.pc_in;
  assign MARin     = w_ctrl.mar_in;
  assign MDRin     = w_ctrl.mdr_in;
  assign IRin      = w_ctrl.ir_in;
  assign Yin       = w_ctrl.y_in;
  assign Rin       = w_ctrl.r_in;
  assign HIin      = w_ctrl.hi_in;
  assign LOin      = w_ctrl.lo_in;
  assign CONin     = w_ctrl.con_in;
  assign IncPC     = w_ctrl.inc_pc;
  assign Read      = w_ctrl.read;
  assign Write     = w_ctrl.write;
  assign Zin_low   = w_ctrl.zlo_in;
  assign Zin_high  = w_ctrl.zhi_in;
  assign Gra       = w_ctrl.gra;
  assign Grb       = w_ctrl.grb;
  assign Grc       = w_ctrl.grc;
  assign operation = ALU_OP_W'(w_ctrl.alu);
  assign step      = r_state;
  assign halted    = (r_state == S_HALT);
  assign fault     = r_fault;

endmodule
